ux607_axi_sram_ctrl: RTL and testbench
======================================

UX607_AXI_SRAM_CTRL -- requirements
Module: ux607_axi_sram_ctrl

Interface
REQ-001 Parameter AW, default 32: AXI address width.
REQ-002 Parameter DW, default 64: data width; legal values 32, 64, 128.
REQ-003 Parameter ID_W, default 4: AXI ID width.
REQ-004 Parameter RAM_AW, default 12: SRAM word-address width; depth is 2^RAM_AW words.
REQ-005 clk  in  1  sole clock; all logic rises on posedge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 AR group: axi_arvalid in 1, axi_arready out 1, axi_arid in ID_W, axi_araddr in AW, axi_arlen in 8, axi_arburst in 2.
REQ-008 AW group: axi_awvalid in 1, axi_awready out 1, axi_awid in ID_W, axi_awaddr in AW, axi_awlen in 8, axi_awburst in 2.
REQ-009 W group: axi_wvalid in 1, axi_wready out 1, axi_wdata in DW, axi_wstrb in DW/8, axi_wlast in 1.
REQ-010 B group: axi_bvalid out 1, axi_bready in 1, axi_bid out ID_W, axi_bresp out 2.
REQ-011 R group: axi_rvalid out 1, axi_rready in 1, axi_rid out ID_W, axi_rdata out DW, axi_rresp out 2, axi_rlast out 1.
REQ-012 SRAM: ram_cs out 1, ram_we out 1, ram_addr out RAM_AW, ram_wem out DW/8, ram_din out DW, ram_dout in DW; read data valid exactly one cycle after a ram_cs read.

Function
REQ-013 FSM states: IDLE, WR, WRESP, RD; exactly one burst in service at a time.
REQ-014 In IDLE with only one of arvalid/awvalid high, the bridge grants that channel; with both high, it grants the channel opposite the last granted one (round-robin).
REQ-015 The bridge asserts the granted arready/awready for one cycle in IDLE, latching ID, word address, len and burst, then moves to RD/WR.
REQ-016 Word address = addr[RAM_AW+LSB-1:LSB], LSB = log2(DW/8); the bridge ignores low bits (aligns down) and ignores high bits (aliases).
REQ-017 Transfers are always full width; the bridge ignores size, applies byte enables only through wstrb, and returns full words on reads.
REQ-018 Next-address rules: FIXED keeps the address; INCR adds 1 modulo 2^RAM_AW; reserved burst (2'b11) is treated as INCR.
REQ-019 WR: wready=1; each wvalid beat drives ram_cs=1, ram_we=1, ram_wem=wstrb, ram_din=wdata in the same cycle; the bridge counts beats.
REQ-020 A W beat with wlast=1 ends the burst and moves to WRESP; bresp=SLVERR(2'b10) if beat count != awlen+1, else OKAY.
REQ-021 WRESP: bvalid stays high with a stable bid/bresp until bready, then IDLE.
REQ-022 RD: the bridge issues a ram read (ram_cs=1, ram_we=0) only when buffered plus in-flight beats < 2, using a 2-entry read buffer, so that rready back-pressure never drops data.
REQ-023 R beats carry the latched rid, rresp=OKAY, and rlast=1 on beat arlen; after the rlast handshake the FSM enters IDLE.
REQ-024 R beats are strictly in address order; zero-bubble throughput is 1 beat/cycle while rready=1.
REQ-025 ram_cs=0 whenever no access is being issued.

Reset
REQ-026 On rst_n low, all ready/valid outputs, ram_cs, and ram_we are 0, the FSM is IDLE, the read buffer is empty, and round-robin gives READ priority first.
REQ-027 Reset mid-burst aborts the burst silently; no B/R response is issued afterwards.

Configuration
REQ-028 With macro UX607_AXI_SRAM_CTRL_WRAP_EN defined, WRAP bursts wrap within an (len+1)-word aligned window, for len in {1,3,7,15}; other lens are treated as INCR.
REQ-029 With UX607_AXI_SRAM_CTRL_WRAP_EN undefined, WRAP is treated as INCR and no wrap logic exists.

Structure
REQ-030 Package ux607_axi_sram_ctrl_pkg holds the burst encodings, resp encodings (OKAY/SLVERR), and FSM state enum.
REQ-031 Sub-module ux607_axi_sram_addr_gen computes the next word address from (addr, len, burst).

Verification
REQ-032 INCR write at awaddr=0x100 with DW=64, awlen=3, wstrb=0xFF -> ram_addr 0x20..0x23 written on consecutive cycles, then bresp=OKAY with matching bid.
REQ-033 Read at araddr=0x100, arlen=3, rready low for 5 cycles mid-burst -> 4 beats returned in order, no loss, rlast on beat 4, and at most 2 reads outstanding.
REQ-034 With WRAP_EN, WRAP read at araddr=0x118, arlen=3 -> words 0x23,0x20,0x21,0x22; without the macro -> 0x23,0x24,0x25,0x26.
REQ-035 awvalid and arvalid raised in the same cycle twice after reset -> read granted first, then write.
REQ-036 Write burst awlen=3 with wlast on beat 2 -> bresp=SLVERR, and 2 SRAM writes only.
REQ-037 rst_n asserted during beat 2 of a read -> rvalid=0 immediately, FSM is IDLE, and the next AR is accepted normally.

Source files
------------

// File: rtl/ux607_axi_sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ux607_axi_sram_ctrl_pkg
// Shared encodings for the AXI-to-SRAM bridge: AXI burst types, AXI response
// codes, the bridge FSM state enum and a helper that says whether a burst
// length is a legal WRAP length.
// No ports (package).
// ---------------------------------------------------------------------------
package ux607_axi_sram_ctrl_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR    = 2'd1,
        ST_WRESP = 2'd2,
        ST_RD    = 2'd3
    } state_t;

    // WRAP windows are only defined for 2, 4, 8 and 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/ux607_axi_sram_addr_gen.sv
// ---------------------------------------------------------------------------
// ux607_axi_sram_addr_gen
// Combinational next-word-address calculation for one AXI burst beat.
//   i_addr  : current SRAM word address
//   i_len   : AXI burst length (beats - 1)
//   i_burst : AXI burst type
//   o_next  : word address of the following beat
// FIXED holds the address, INCR and the reserved encoding add one modulo the
// SRAM depth. WRAP wraps inside an aligned (len+1)-word window only when the
// macro UX607_AXI_SRAM_CTRL_WRAP_EN is defined; otherwise WRAP behaves as INCR.
// ---------------------------------------------------------------------------
module ux607_axi_sram_addr_gen
    import ux607_axi_sram_ctrl_pkg::*;
#(
    parameter int RAM_AW = 12
) (
    input  logic [RAM_AW-1:0] i_addr,
    input  logic [7:0]        i_len,
    input  logic [1:0]        i_burst,
    output logic [RAM_AW-1:0] o_next
);

    logic [RAM_AW-1:0] w_incr;
    assign w_incr = i_addr + RAM_AW'(1);

`ifdef UX607_AXI_SRAM_CTRL_WRAP_EN
    // Legal wrap lengths are 2^n-1, so len itself is the in-window offset mask.
    logic [RAM_AW-1:0] w_mask;
    logic [RAM_AW-1:0] w_wrap;
    assign w_mask = RAM_AW'(i_len[3:0]);
    assign w_wrap = (i_addr & ~w_mask) | (w_incr & w_mask);

    always_comb begin
        o_next = w_incr;
        case (i_burst)
            BURST_FIXED: o_next = i_addr;
            BURST_WRAP:  o_next = wrap_len_ok(i_len) ? w_wrap : w_incr;
            BURST_INCR,
            BURST_RSVD:  o_next = w_incr;
            default:     o_next = w_incr;
        endcase
    end
`else
    logic w_len_unused;
    assign w_len_unused = ^i_len;

    always_comb begin
        o_next = w_incr;
        case (i_burst)
            BURST_FIXED: o_next = i_addr;
            BURST_INCR,
            BURST_WRAP,
            BURST_RSVD:  o_next = w_incr;
            default:     o_next = w_incr;
        endcase
    end
`endif

endmodule

// File: rtl/ux607_axi_sram_ctrl.sv
// ---------------------------------------------------------------------------
// ux607_axi_sram_ctrl
// AXI slave to single-port synchronous SRAM bridge. One burst is serviced at a
// time; simultaneous read/write requests are arbitrated round-robin (read
// first after reset). Reads use a 2-entry return buffer so R back-pressure
// never loses data while still sustaining one beat per cycle.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   axi_ar* / axi_aw*     : read / write address channels
//   axi_w*                : write data channel (full-width beats, wstrb masks)
//   axi_b*                : write response channel
//   axi_r*                : read data channel
//   ram_cs/we/addr/wem/din: SRAM request, ram_dout valid one cycle after a read
// Optional feature: define UX607_AXI_SRAM_CTRL_WRAP_EN for real WRAP bursts.
// ---------------------------------------------------------------------------
module ux607_axi_sram_ctrl
    import ux607_axi_sram_ctrl_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 64,
    parameter int ID_W   = 4,
    parameter int RAM_AW = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              axi_arvalid,
    output logic              axi_arready,
    input  logic [ID_W-1:0]   axi_arid,
    input  logic [AW-1:0]     axi_araddr,
    input  logic [7:0]        axi_arlen,
    input  logic [1:0]        axi_arburst,
    input  logic              axi_awvalid,
    output logic              axi_awready,
    input  logic [ID_W-1:0]   axi_awid,
    input  logic [AW-1:0]     axi_awaddr,
    input  logic [7:0]        axi_awlen,
    input  logic [1:0]        axi_awburst,
    input  logic              axi_wvalid,
    output logic              axi_wready,
    input  logic [DW-1:0]     axi_wdata,
    input  logic [DW/8-1:0]   axi_wstrb,
    input  logic              axi_wlast,
    output logic              axi_bvalid,
    input  logic              axi_bready,
    output logic [ID_W-1:0]   axi_bid,
    output logic [1:0]        axi_bresp,
    output logic              axi_rvalid,
    input  logic              axi_rready,
    output logic [ID_W-1:0]   axi_rid,
    output logic [DW-1:0]     axi_rdata,
    output logic [1:0]        axi_rresp,
    output logic              axi_rlast,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW/8-1:0]   ram_wem,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout
);

    localparam int NB  = DW / 8;
    localparam int LSB = $clog2(NB);

    state_t            r_state;
    logic              r_ready_en;
    logic              r_last_rd;
    logic [ID_W-1:0]   r_id;
    logic [RAM_AW-1:0] r_addr;
    logic [7:0]        r_len;
    logic [1:0]        r_burst;
    logic [8:0]        r_wcnt;
    logic [1:0]        r_bresp;
    logic [8:0]        r_rd_iss;
    logic [7:0]        r_rd_beat;
    logic              r_inflight;
    logic [1:0]        r_cnt;
    logic              r_wptr;
    logic              r_rptr;
    logic [DW-1:0]     r_buf [2];

    logic              w_grant_rd;
    logic              w_grant_wr;
    logic              w_wbeat;
    logic              w_rd_issue;
    logic              w_rpop;
    logic              w_push_store;
    logic              w_pop_buf;
    logic              w_rlast;
    logic [RAM_AW-1:0] w_next_addr;
    logic              w_addr_unused;

    assign w_addr_unused = ^{axi_araddr[LSB-1:0], axi_araddr[AW-1:RAM_AW+LSB],
                             axi_awaddr[LSB-1:0], axi_awaddr[AW-1:RAM_AW+LSB]};

    // Round-robin: on a tie, read wins unless the previous grant was a read.
    assign w_grant_rd = axi_arvalid && (!axi_awvalid || !r_last_rd);
    assign w_grant_wr = axi_awvalid && !w_grant_rd;

    // r_ready_en keeps both address channels closed while reset is asserted.
    assign axi_arready = r_ready_en && (r_state == ST_IDLE) && w_grant_rd;
    assign axi_awready = r_ready_en && (r_state == ST_IDLE) && w_grant_wr;

    assign axi_wready  = (r_state == ST_WR);
    assign w_wbeat     = (r_state == ST_WR) && axi_wvalid;

    assign axi_bvalid  = (r_state == ST_WRESP);
    assign axi_bid     = r_id;
    assign axi_bresp   = r_bresp;

    // A read may issue only while buffered + in-flight beats stay below two,
    // so every returning word always has a buffer slot even under rready=0.
    assign w_rd_issue  = (r_state == ST_RD) && (r_rd_iss <= {1'b0, r_len}) &&
                         ((r_cnt + {1'b0, r_inflight}) < 2'd2);

    // The oldest beat is the buffer head; with an empty buffer the word
    // arriving from the SRAM is presented directly (zero-bubble path).
    assign axi_rvalid  = (r_cnt != 2'd0) || r_inflight;
    assign axi_rdata   = (r_cnt != 2'd0) ? r_buf[r_rptr] : ram_dout;
    assign axi_rid     = r_id;
    assign axi_rresp   = RESP_OKAY;
    assign w_rlast     = (r_rd_beat == r_len);
    assign axi_rlast   = w_rlast;
    assign w_rpop      = axi_rvalid && axi_rready;
    assign w_push_store = r_inflight && !((r_cnt == 2'd0) && w_rpop);
    assign w_pop_buf   = w_rpop && (r_cnt != 2'd0);

    assign ram_cs      = w_wbeat || w_rd_issue;
    assign ram_we      = w_wbeat;
    assign ram_addr    = r_addr;
    assign ram_wem     = w_wbeat ? axi_wstrb : '0;
    assign ram_din     = w_wbeat ? axi_wdata : '0;

    ux607_axi_sram_addr_gen #(
        .RAM_AW (RAM_AW)
    ) u_addr_gen (
        .i_addr  (r_addr),
        .i_len   (r_len),
        .i_burst (r_burst),
        .o_next  (w_next_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ready_en <= 1'b0;
            r_last_rd  <= 1'b0;
            r_id       <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_burst    <= BURST_INCR;
            r_wcnt     <= '0;
            r_bresp    <= RESP_OKAY;
            r_rd_iss   <= '0;
            r_rd_beat  <= '0;
            r_inflight <= 1'b0;
            r_cnt      <= '0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (axi_arready) begin
                        r_id      <= axi_arid;
                        r_addr    <= axi_araddr[RAM_AW+LSB-1:LSB];
                        r_len     <= axi_arlen;
                        r_burst   <= axi_arburst;
                        r_rd_iss  <= '0;
                        r_rd_beat <= '0;
                        r_last_rd <= 1'b1;
                        r_state   <= ST_RD;
                    end else if (axi_awready) begin
                        r_id      <= axi_awid;
                        r_addr    <= axi_awaddr[RAM_AW+LSB-1:LSB];
                        r_len     <= axi_awlen;
                        r_burst   <= axi_awburst;
                        r_wcnt    <= '0;
                        r_last_rd <= 1'b0;
                        r_state   <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (w_wbeat) begin
                        r_addr <= w_next_addr;
                        r_wcnt <= r_wcnt + 9'd1;
                        if (axi_wlast) begin
                            // r_wcnt counts beats before this one.
                            r_bresp <= (r_wcnt == {1'b0, r_len}) ? RESP_OKAY : RESP_SLVERR;
                            r_state <= ST_WRESP;
                        end
                    end
                end
                ST_WRESP: begin
                    if (axi_bready) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    if (w_rd_issue) begin
                        r_addr   <= w_next_addr;
                        r_rd_iss <= r_rd_iss + 9'd1;
                    end
                    if (w_rpop) begin
                        r_rd_beat <= r_rd_beat + 8'd1;
                        if (w_rlast) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            r_inflight <= w_rd_issue;
            if (w_push_store) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop_buf) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push_store, w_pop_buf})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_store) begin
            r_buf[r_wptr] <= ram_dout;
        end
    end

endmodule

// File: tb/tb_ux607_axi_sram_ctrl.sv
`timescale 1ns/1ps
module tb_ux607_axi_sram_ctrl;
    localparam int AW = 32, DW = 64, ID_W = 4, RAM_AW = 12;
    localparam int NB = DW / 8;
    localparam int DEPTH = 1 << RAM_AW;

    logic clk = 1'b0;
    logic rst_n;
    logic axi_arvalid, axi_arready, axi_awvalid, axi_awready;
    logic [ID_W-1:0] axi_arid, axi_awid, axi_bid, axi_rid;
    logic [AW-1:0] axi_araddr, axi_awaddr;
    logic [7:0] axi_arlen, axi_awlen;
    logic [1:0] axi_arburst, axi_awburst, axi_bresp, axi_rresp;
    logic axi_wvalid, axi_wready, axi_wlast, axi_bvalid, axi_bready;
    logic [DW-1:0] axi_wdata, axi_rdata, ram_din, ram_dout;
    logic [NB-1:0] axi_wstrb, ram_wem;
    logic axi_rvalid, axi_rready, axi_rlast, ram_cs, ram_we;
    logic [RAM_AW-1:0] ram_addr;

    always #5 clk = ~clk;

    ux607_axi_sram_ctrl #(.AW(AW), .DW(DW), .ID_W(ID_W), .RAM_AW(RAM_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arburst(axi_arburst),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awburst(axi_awburst),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bid(axi_bid), .axi_bresp(axi_bresp),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rid(axi_rid), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // ---------------- SRAM environment ----------------
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < NB; b++)
                    if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
    end

    // ---------------- behavioural model ----------------
    logic [DW-1:0] shadow [DEPTH];
    typedef struct { logic [RAM_AW-1:0] a; logic [NB-1:0] m; logic [DW-1:0] d; } wexp_t;
    typedef struct { logic [DW-1:0] d; logic [ID_W-1:0] id; logic last; } rexp_t;
    typedef struct { logic [ID_W-1:0] id; logic [1:0] resp; } bexp_t;
    wexp_t wq[$];
    rexp_t rq[$];
    bexp_t bq[$];

    int tests = 0, fails = 0;
    int cyc = 0, issued = 0, consumed = 0, max_out = 0, rbeats = 0;
    logic [RAM_AW-1:0] wlog[$], rlog[$];
    int wcyc[$], rcyc[$], glog[$];
    logic [1:0] lastb_resp;
    logic [ID_W-1:0] lastb_id;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    function automatic logic [RAM_AW-1:0] word_of(input logic [AW-1:0] a);
        return RAM_AW'((a / NB) % DEPTH);
    endfunction

    function automatic logic [RAM_AW-1:0] next_word(input logic [RAM_AW-1:0] a, input logic [7:0] len, input logic [1:0] burst);
        int unsigned ai, n;
        ai = int'(a);
        if (burst == 2'b00) return a;
`ifdef UX607_AXI_SRAM_CTRL_WRAP_EN
        if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            n = int'(len) + 1;
            return RAM_AW'((ai / n) * n + ((ai % n) + 1) % n);
        end
`endif
        return RAM_AW'((ai + 1) % DEPTH);
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (axi_arvalid && axi_arready) glog.push_back(0);
            if (axi_awvalid && axi_awready) glog.push_back(1);
            if (ram_cs && ram_we) begin
                wlog.push_back(ram_addr);
                wcyc.push_back(cyc);
                if (wq.size() == 0) fail_now("unexpected_sram_write");
                else begin
                    wexp_t e;
                    e = wq.pop_front();
                    chk("ram_addr_wr", ram_addr, e.a);
                    chk("ram_wem", ram_wem, e.m);
                    chk("ram_din", ram_din, e.d);
                end
            end
            if (ram_cs && !ram_we) begin
                rlog.push_back(ram_addr);
                issued++;
            end
            if (axi_rvalid && axi_rready) begin
                consumed++;
                rbeats++;
                rcyc.push_back(cyc);
                if (rq.size() == 0) fail_now("unexpected_r_beat");
                else begin
                    rexp_t e;
                    e = rq.pop_front();
                    chk("rdata", axi_rdata, e.d);
                    chk("rid", axi_rid, e.id);
                    chk("rlast", axi_rlast, e.last);
                    chk("rresp", axi_rresp, 2'b00);
                end
            end
            if (issued - consumed > max_out) max_out = issued - consumed;
            if (axi_bvalid) begin
                if (bq.size() == 0) fail_now("unexpected_bvalid");
                else begin
                    chk("bid", axi_bid, bq[0].id);
                    chk("bresp", axi_bresp, bq[0].resp);
                    if (axi_bready) begin
                        lastb_resp = axi_bresp;
                        lastb_id = axi_bid;
                        void'(bq.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic do_write(input logic [ID_W-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int nbeats, input bit gaps, input bit full_strb, input int bdly);
        logic [DW-1:0] d[$];
        logic [NB-1:0] s[$];
        logic [RAM_AW-1:0] wa;
        wexp_t e;
        bexp_t be;
        int n, dly;
        wa = word_of(addr);
        for (int i = 0; i < nbeats; i++) begin
            logic [DW-1:0] dv;
            logic [NB-1:0] sv;
            dv = {$urandom, $urandom};
            sv = full_strb ? '1 : NB'($urandom);
            d.push_back(dv);
            s.push_back(sv);
            e.a = wa; e.m = sv; e.d = dv;
            wq.push_back(e);
            for (int b = 0; b < NB; b++) if (sv[b]) shadow[wa][8*b +: 8] = dv[8*b +: 8];
            wa = next_word(wa, len, burst);
        end
        be.id = id;
        be.resp = (nbeats == int'(len) + 1) ? 2'b00 : 2'b10;
        bq.push_back(be);
        axi_awvalid = 1'b1; axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awburst = burst;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi_awready && n < 500);
        if (!axi_awready) fail_now("aw_handshake_timeout");
        @(posedge clk); #1;
        axi_awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            axi_wvalid = 1'b1; axi_wdata = d[i]; axi_wstrb = s[i]; axi_wlast = (i == nbeats - 1);
            n = 0;
            do begin @(negedge clk); n++; end while (!axi_wready && n < 500);
            if (!axi_wready) fail_now("w_handshake_timeout");
            @(posedge clk); #1;
            axi_wvalid = 1'b0; axi_wlast = 1'b0;
        end
        dly = bdly;
        n = 0;
        while (bq.size() != 0 && n < 500) begin
            axi_bready = (dly == 0);
            if (dly > 0) dly--;
            @(posedge clk); #1;
            n++;
        end
        axi_bready = 1'b0;
        if (bq.size() != 0) begin
            fail_now("b_response_timeout");
            bq.delete();
        end
    endtask

    task automatic prep_read(input logic [ID_W-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len, input logic [1:0] burst);
        logic [RAM_AW-1:0] ra;
        rexp_t e;
        ra = word_of(addr);
        for (int i = 0; i <= int'(len); i++) begin
            e.d = shadow[ra]; e.id = id; e.last = (i == int'(len));
            rq.push_back(e);
            ra = next_word(ra, len, burst);
        end
    endtask

    task automatic ar_handshake(input logic [ID_W-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int n;
        axi_arvalid = 1'b1; axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arburst = burst;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi_arready && n < 500);
        if (!axi_arready) fail_now("ar_handshake_timeout");
        @(posedge clk); #1;
        axi_arvalid = 1'b0;
    endtask

    // mode 0: rready always high, 1: random, 2: stall five cycles after beat 1
    task automatic do_read(input logic [ID_W-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int mode);
        int n, st, base;
        prep_read(id, addr, len, burst);
        ar_handshake(id, addr, len, burst);
        st = 0; n = 0; base = rbeats;
        while (rq.size() != 0 && n < 1000) begin
            case (mode)
                0: axi_rready = 1'b1;
                1: axi_rready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (rbeats - base >= 1 && st < 5) begin axi_rready = 1'b0; st++; end
                    else axi_rready = 1'b1;
                end
            endcase
            @(posedge clk); #1;
            n++;
        end
        axi_rready = 1'b0;
        if (rq.size() != 0) begin
            fail_now("r_burst_timeout");
            rq.delete();
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_rvalid", axi_rvalid, 1'b0);
        chk("rst_bvalid", axi_bvalid, 1'b0);
        chk("rst_ram_cs", ram_cs, 1'b0);
        rq.delete(); wq.delete(); bq.delete();
        issued = 0; consumed = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RAM_AW-1:0] wrap_exp [4];
        int quiet, n, base;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = {$urandom, $urandom};
            shadow[i] = mem[i];
        end
        ram_dout = '0;
        rst_n = 1'b0;
        axi_arvalid = 1'b1; axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arburst = 2'b01;
        axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awburst = 2'b01;
        axi_wdata = '0; axi_wstrb = '1; axi_wlast = 1'b1; axi_bready = 1'b1; axi_rready = 1'b1;
        repeat (3) @(negedge clk);
        // Reset state with every request asserted
        chk("reset_arready", axi_arready, 1'b0);
        chk("reset_awready", axi_awready, 1'b0);
        chk("reset_wready", axi_wready, 1'b0);
        chk("reset_bvalid", axi_bvalid, 1'b0);
        chk("reset_rvalid", axi_rvalid, 1'b0);
        chk("reset_ram_cs", ram_cs, 1'b0);
        chk("reset_ram_we", ram_we, 1'b0);
        axi_arvalid = 1'b0; axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_wlast = 1'b0;
        axi_bready = 1'b0; axi_rready = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // INCR write at 0x100, four full beats back to back
        wlog.delete(); wcyc.delete();
        do_write(4'h5, 32'h100, 8'd3, 2'b01, 4, 1'b0, 1'b1, 0);
        chk("w32_count", wlog.size(), 4);
        if (wlog.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("w32_addr", wlog[i], 12'h020 + i);
            chk("w32_consecutive", wcyc[3] - wcyc[0], 3);
        end
        chk("w32_bresp", lastb_resp, 2'b00);
        chk("w32_bid", lastb_id, 4'h5);

        // Read back with a five-cycle rready stall mid-burst
        max_out = 0; base = rbeats;
        do_read(4'h9, 32'h100, 8'd3, 2'b01, 2);
        chk("r33_beats", rbeats - base, 4);
        chk("r33_max_outstanding_le2", (max_out <= 2), 1'b1);

        // WRAP read at 0x118
        rlog.delete();
`ifdef UX607_AXI_SRAM_CTRL_WRAP_EN
        wrap_exp[0] = 12'h023; wrap_exp[1] = 12'h020; wrap_exp[2] = 12'h021; wrap_exp[3] = 12'h022;
`else
        wrap_exp[0] = 12'h023; wrap_exp[1] = 12'h024; wrap_exp[2] = 12'h025; wrap_exp[3] = 12'h026;
`endif
        do_read(4'h2, 32'h118, 8'd3, 2'b10, 0);
        chk("wrap_issue_count", rlog.size(), 4);
        if (rlog.size() == 4) for (int i = 0; i < 4; i++) chk("wrap_addr", rlog[i], wrap_exp[i]);

        // Zero-bubble 8-beat read
        rcyc.delete();
        do_read(4'h1, 32'h2000, 8'd7, 2'b01, 0);
        chk("zero_bubble_beats", rcyc.size(), 8);
        if (rcyc.size() == 8) chk("zero_bubble_span", rcyc[7] - rcyc[0], 7);

        // Early wlast: awlen=3, wlast on beat 2
        wlog.delete();
        do_write(4'h7, 32'h3000, 8'd3, 2'b01, 2, 1'b1, 1'b0, 2);
        chk("early_wlast_writes", wlog.size(), 2);
        chk("early_wlast_bresp", lastb_resp, 2'b10);

        // Simultaneous AR/AW twice after reset
        pulse_reset();
        glog.delete();
        for (int k = 0; k < 2; k++) begin
            fork
                do_read(4'h3, 32'h4000 + 32'(k * 256), 8'd2, 2'b01, 1);
                do_write(4'h4, 32'h6000 + 32'(k * 256), 8'd1, 2'b01, 2, 1'b1, 1'b0, 1);
            join
        end
        chk("grant_count", glog.size(), 4);
        if (glog.size() == 4) begin
            chk("grant0_read", glog[0], 0);
            chk("grant1_write", glog[1], 1);
            chk("grant2_read", glog[2], 0);
            chk("grant3_write", glog[3], 1);
        end

        // Reset asserted while beat 2 of a read is presented
        prep_read(4'h6, 32'h5000, 8'd7, 2'b01);
        ar_handshake(4'h6, 32'h5000, 8'd7, 2'b01);
        axi_rready = 1'b1;
        base = rbeats; n = 0;
        do begin @(negedge clk); n++; end while (!((rbeats - base == 1) && axi_rvalid) && n < 100);
        if (n >= 100) fail_now("beat2_wait_timeout");
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_rvalid", axi_rvalid, 1'b0);
        chk("midreset_ram_cs", ram_cs, 1'b0);
        rq.delete(); issued = 0; consumed = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        quiet = 0;
        repeat (6) begin
            @(negedge clk);
            if (axi_rvalid || axi_bvalid) quiet++;
        end
        chk("midreset_no_response", quiet, 0);
        @(posedge clk); #1 axi_rready = 1'b0;
        base = rbeats;
        do_read(4'h8, 32'h5000, 8'd1, 2'b01, 0);
        chk("after_reset_read_beats", rbeats - base, 2);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            logic [7:0] len;
            logic [1:0] burst;
            logic [AW-1:0] addr;
            int nb;
            len = 8'($urandom_range(0, 15));
            burst = 2'($urandom_range(0, 3));
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                nb = int'(len) + 1;
                if ($urandom_range(0, 7) == 0 && len > 0) nb = $urandom_range(1, int'(len));
                do_write(4'($urandom), addr, len, burst, nb, 1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 3));
            end else begin
                do_read(4'($urandom), addr, len, burst, $urandom_range(0, 2));
            end
        end
        repeat (4) @(posedge clk);
        chk("end_wq_empty", wq.size(), 0);
        chk("end_rq_empty", rq.size(), 0);
        chk("end_bq_empty", bq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
